// File: rtl/scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// scan_decoder_pkg
// Shared constants and helpers for the scan decoder slice.
//   MODE_DIRECT / MODE_SCAN : encodings of the MODE input
//   cnt_width()             : width of a counter that must hold 0..max_count-1,
//                             never less than one bit
// -----------------------------------------------------------------------------
package scan_decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter width for values 0..max_count-1; a degenerate count still gets a
  // one-bit register so the counter always exists as a real signal.
  function automatic int cnt_width(input int max_count);
    if (max_count <= 1) begin
      return 1;
    end else begin
      return $clog2(max_count);
    end
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
// Combinational N -> 2**N one-hot decode.
//   en  : when low the output is all-zero
//   idx : index to decode
//   y   : one-hot of idx, or all-zero when disabled or idx >= COUNT
// -----------------------------------------------------------------------------
module onehot_decoder #(
  parameter int N     = 2,
  parameter int COUNT = 2 ** N
) (
  input  logic               en,
  input  logic [N-1:0]       idx,
  output logic [(2**N)-1:0]  y
);

  localparam int W = 2 ** N;

  // Decode; indices at or above COUNT are not wired to any output.
  always_comb begin
    y = {W{1'b0}};
    if (en && (int'(idx) < COUNT)) begin
      y[idx] = 1'b1;
    end else begin
      y = {W{1'b0}};
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// Registered one-hot decoder with direct-select and auto-scan modes plus
// break-before-make blanking whenever the selected index changes.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   E    : enable; low blanks D and freezes SEL and the prescaler
//   MODE : MODE_DIRECT (SEL follows A) or MODE_SCAN (SEL steps every DIV cycles)
//   A    : select index used in direct mode
//   D    : registered one-hot of SEL (all-zero while blanked/disabled/out of range)
//   SEL  : registered current index
//   TICK : registered one-cycle pulse on each scan step
// -----------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int COUNT = 2 ** N,
  parameter int DIV   = 4,
  parameter int DEAD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic              MODE,
  input  logic [N-1:0]      A,
  output logic [(2**N)-1:0] D,
  output logic [N-1:0]      SEL,
  output logic              TICK
);

  localparam int W  = 2 ** N;
  localparam int PW = cnt_width(DIV);
  localparam int BW = cnt_width(DEAD);

  localparam logic [N-1:0]  SEL_LAST   = N'(COUNT - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  // The change edge itself is the first blank cycle, so DEAD-1 remain after it.
  localparam logic [BW-1:0] BLANK_LOAD = BW'((DEAD > 0) ? (DEAD - 1) : 0);

  generate
    if ((N < 1) || (COUNT < 1) || (COUNT > (2 ** N)) || (DIV < 1) || (DEAD < 0)) begin : g_bad_param
      $error("scan_decoder: illegal parameter set (need N>=1, 1<=COUNT<=2**N, DIV>=1, DEAD>=0)");
    end
  endgenerate

  logic [N-1:0]  sel_r;
  logic [PW-1:0] presc_r;
  logic [BW-1:0] blank_r;
  logic [W-1:0]  d_r;
  logic          tick_r;
  logic          mode_r;
  logic          en_r;

  logic [N-1:0]  sel_nxt_s;
  logic [PW-1:0] presc_nxt_s;
  logic [BW-1:0] blank_nxt_s;
  logic          tick_nxt_s;
  logic          mode_nxt_s;
  logic          sel_chg_s;
  logic          blank_act_s;
  logic          dec_en_s;
  logic [W-1:0]  dec_y_s;

  // Next-state for select, prescaler, tick and blanking.
  always_comb begin
    sel_nxt_s   = sel_r;
    presc_nxt_s = presc_r;
    blank_nxt_s = blank_r;
    tick_nxt_s  = 1'b0;
    mode_nxt_s  = mode_r;
    sel_chg_s   = 1'b0;
    blank_act_s = 1'b0;

    if (!E) begin
      // Disabled: everything frozen except blanking, which is re-armed by the
      // enable rising edge anyway.
      blank_nxt_s = {BW{1'b0}};
    end else begin
      mode_nxt_s = MODE;
      case (MODE)
        MODE_DIRECT: begin
          sel_nxt_s   = A;
          presc_nxt_s = {PW{1'b0}};
        end
        MODE_SCAN: begin
          if (mode_r != MODE) begin
            // Entering scan: restart the prescaler, no step on this edge even
            // if it would have wrapped.
            presc_nxt_s = {PW{1'b0}};
          end else if (presc_r == PRESC_LAST) begin
            presc_nxt_s = {PW{1'b0}};
            tick_nxt_s  = 1'b1;
            // >= also catches an out-of-range SEL inherited from direct mode.
            if (sel_r >= SEL_LAST) begin
              sel_nxt_s = {N{1'b0}};
            end else begin
              sel_nxt_s = sel_r + N'(1'b1);
            end
          end else begin
            presc_nxt_s = presc_r + PW'(1'b1);
          end
        end
        default: begin
          sel_nxt_s   = sel_r;
          presc_nxt_s = presc_r;
        end
      endcase

      // Re-enabling counts as a select change so the output is blanked too.
      sel_chg_s = (sel_nxt_s != sel_r) || !en_r;

      if (DEAD == 0) begin
        blank_nxt_s = {BW{1'b0}};
        blank_act_s = 1'b0;
      end else if (sel_chg_s) begin
        // A change during blanking restarts the count.
        blank_nxt_s = BLANK_LOAD;
        blank_act_s = 1'b1;
      end else if (blank_r != {BW{1'b0}}) begin
        blank_nxt_s = blank_r - BW'(1'b1);
        blank_act_s = 1'b1;
      end else begin
        blank_nxt_s = {BW{1'b0}};
        blank_act_s = 1'b0;
      end
    end
  end

  assign dec_en_s = E && !blank_act_s;

  onehot_decoder #(
    .N     (N),
    .COUNT (COUNT)
  ) u_onehot_decoder (
    .en  (dec_en_s),
    .idx (sel_nxt_s),
    .y   (dec_y_s)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r   <= {N{1'b0}};
      presc_r <= {PW{1'b0}};
      blank_r <= {BW{1'b0}};
      d_r     <= {W{1'b0}};
      tick_r  <= 1'b0;
      mode_r  <= MODE_DIRECT;
      en_r    <= 1'b0;
    end else begin
      sel_r   <= sel_nxt_s;
      presc_r <= presc_nxt_s;
      blank_r <= blank_nxt_s;
      d_r     <= dec_y_s;
      tick_r  <= tick_nxt_s;
      mode_r  <= mode_nxt_s;
      en_r    <= E;
    end
  end

  assign D    = d_r;
  assign SEL  = sel_r;
  assign TICK = tick_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three instances with different parameters share one
// stimulus stream and are compared every cycle against a behavioural model,
// plus a directed vector table and hand-written scan / enable / reset sequences.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       E;
  logic       MODE;
  logic [1:0] A;

  logic [3:0] d0, d1, d2;
  logic [1:0] s0, s1, s2;
  logic       t0, t1, t2;

  int checks = 0;
  int errors = 0;

  // u0: COUNT=3 DIV=4 DEAD=0, u1: COUNT=4 DIV=4 DEAD=1, u2: COUNT=4 DIV=1 DEAD=2
  int cnt_c[3]  = '{3, 4, 4};
  int div_c[3]  = '{4, 4, 1};
  int dead_c[3] = '{0, 1, 2};

  scan_decoder #(.N(2), .COUNT(3), .DIV(4), .DEAD(0)) u0 (
    .clk(clk), .rst(rst), .E(E), .MODE(MODE), .A(A), .D(d0), .SEL(s0), .TICK(t0));
  scan_decoder #(.N(2), .COUNT(4), .DIV(4), .DEAD(1)) u1 (
    .clk(clk), .rst(rst), .E(E), .MODE(MODE), .A(A), .D(d1), .SEL(s1), .TICK(t1));
  scan_decoder #(.N(2), .COUNT(4), .DIV(1), .DEAD(2)) u2 (
    .clk(clk), .rst(rst), .E(E), .MODE(MODE), .A(A), .D(d2), .SEL(s2), .TICK(t2));

  always #5 clk = ~clk;

  // Behavioural model: zeros_left = number of upcoming cycles D must stay dark.
  typedef struct {
    int sel;
    int presc;
    int zeros_left;
    int d;
    int tick;
    int prev_mode;
    int prev_e;
  } mdl_t;
  mdl_t m[3];

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      m[k].sel = 0; m[k].presc = 0; m[k].zeros_left = 0; m[k].d = 0;
      m[k].tick = 0; m[k].prev_mode = 0; m[k].prev_e = 0;
    end
  endtask

  task automatic mstep(input int k);
    mdl_t s;
    int old_sel;
    s = m[k];
    if (E == 1'b0) begin
      s.d = 0; s.tick = 0; s.prev_e = 0;
    end else begin
      old_sel = s.sel;
      s.tick = 0;
      if (MODE == 1'b0) begin
        s.sel = int'(A); s.presc = 0;
      end else if (s.prev_mode != 1) begin
        s.presc = 0;
      end else if (s.presc == div_c[k] - 1) begin
        s.presc = 0; s.tick = 1;
        s.sel = (s.sel + 1 >= cnt_c[k]) ? 0 : s.sel + 1;
      end else begin
        s.presc = s.presc + 1;
      end
      s.prev_mode = int'(MODE);
      if (s.sel != old_sel || s.prev_e == 0) s.zeros_left = dead_c[k];
      if (s.zeros_left > 0) begin
        s.d = 0; s.zeros_left = s.zeros_left - 1;
      end else begin
        s.d = (s.sel < cnt_c[k]) ? (1 << s.sel) : 0;
      end
      s.prev_e = 1;
    end
    m[k] = s;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("u0_D", int'(d0), m[0].d); chk("u0_SEL", int'(s0), m[0].sel); chk("u0_TICK", int'(t0), m[0].tick);
    chk("u1_D", int'(d1), m[1].d); chk("u1_SEL", int'(s1), m[1].sel); chk("u1_TICK", int'(t1), m[1].tick);
    chk("u2_D", int'(d2), m[2].d); chk("u2_SEL", int'(s2), m[2].sel); chk("u2_TICK", int'(t2), m[2].tick);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    #1;
    chk_model();
  endtask

  // Reset pulsed between edges; outputs must clear before the next clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    mreset();
    #1;
    chk({tag, "_u0_D"}, int'(d0), 0); chk({tag, "_u0_SEL"}, int'(s0), 0); chk({tag, "_u0_TICK"}, int'(t0), 0);
    chk({tag, "_u1_D"}, int'(d1), 0); chk({tag, "_u1_SEL"}, int'(s1), 0); chk({tag, "_u1_TICK"}, int'(t1), 0);
    chk({tag, "_u2_D"}, int'(d2), 0); chk({tag, "_u2_SEL"}, int'(s2), 0); chk({tag, "_u2_TICK"}, int'(t2), 0);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       e;
    logic       mode;
    logic [1:0] a;
    logic [3:0] d0;
    logic [1:0] s0;
    logic [3:0] d1;
    logic [1:0] s1;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int exp_sel;
    rst = 1'b1; E = 1'b0; MODE = 1'b0; A = 2'd0;
    mreset();
    #1;
    chk("rst_u0_D", int'(d0), 0); chk("rst_u0_SEL", int'(s0), 0); chk("rst_u0_TICK", int'(t0), 0);
    chk("rst_u1_D", int'(d1), 0); chk("rst_u2_D", int'(d2), 0);
    @(negedge clk);
    rst = 1'b0;

    // Direct mode vectors: e, mode, a, expected u0 D/SEL (DEAD=0, COUNT=3),
    // expected u1 D/SEL (DEAD=1, COUNT=4).
    tbl[0] = '{1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 4'b0000, 2'd2};
    tbl[1] = '{1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 4'b0100, 2'd2};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 4'b0000, 2'd1};
    tbl[3] = '{1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 4'b0010, 2'd1};
    tbl[4] = '{1'b1, 1'b0, 2'd3, 4'b0000, 2'd3, 4'b0000, 2'd3};
    tbl[5] = '{1'b1, 1'b0, 2'd3, 4'b0000, 2'd3, 4'b1000, 2'd3};
    tbl[6] = '{1'b1, 1'b0, 2'd3, 4'b0000, 2'd3, 4'b1000, 2'd3};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 4'b0000, 2'd3, 4'b0000, 2'd3};
    tbl[8] = '{1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 4'b0000, 2'd0};
    tbl[9] = '{1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 4'b0001, 2'd0};
    for (int i = 0; i < 10; i++) begin
      E = tbl[i].e; MODE = tbl[i].mode; A = tbl[i].a;
      cycle();
      chk($sformatf("tbl%0d_u0_D", i), int'(d0), int'(tbl[i].d0));
      chk($sformatf("tbl%0d_u0_SEL", i), int'(s0), int'(tbl[i].s0));
      chk($sformatf("tbl%0d_u1_D", i), int'(d1), int'(tbl[i].d1));
      chk($sformatf("tbl%0d_u1_SEL", i), int'(s1), int'(tbl[i].s1));
      chk($sformatf("tbl%0d_u0_TICK", i), int'(t0), 0);
    end

    // Scan from SEL=0: step k=0 is the mode-change edge (no tick).
    MODE = 1'b1; E = 1'b1; A = 2'd0;
    for (int k = 0; k <= 16; k++) begin
      cycle();
      exp_sel = (k / 4) % 3;
      chk($sformatf("scan%0d_u0_TICK", k), int'(t0), (k > 0 && k % 4 == 0) ? 1 : 0);
      chk($sformatf("scan%0d_u0_SEL", k), int'(s0), exp_sel);
      chk($sformatf("scan%0d_u0_D", k), int'(d0), 1 << exp_sel);
      chk($sformatf("scan%0d_u0_D3", k), int'(d0[3]), 0);
      chk($sformatf("scan%0d_u2_TICK", k), int'(t2), (k > 0) ? 1 : 0);
    end
    // Four more edges bring u1 (COUNT=4) to SEL=1, still blanking.
    for (int k = 0; k < 4; k++) cycle();
    chk("pre_drop_u1_SEL", int'(s1), 1);

    // Enable dropped: dark, SEL held, no tick.
    E = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("edrop%0d_u1_D", k), int'(d1), 0);
      chk($sformatf("edrop%0d_u1_SEL", k), int'(s1), 1);
      chk($sformatf("edrop%0d_u1_TICK", k), int'(t1), 0);
    end
    // Enable raised: one blank cycle, then 0010, scan resumes from held prescaler.
    E = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cycle();
      chk($sformatf("erise%0d_u1_D", r), int'(d1), (r == 1 || r == 2) ? 4'b0010 : 4'b0000);
      chk($sformatf("erise%0d_u1_SEL", r), int'(s1), (r < 3) ? 1 : 2);
      chk($sformatf("erise%0d_u1_TICK", r), int'(t1), (r == 3) ? 1 : 0);
    end

    // Reset in the middle of a scan.
    for (int k = 0; k < 2; k++) cycle();
    async_reset("midscan");

    // Randomised traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      E = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) MODE = ~MODE;
      A = 2'($urandom_range(0, 3));
      cycle();
      if (i == 200) async_reset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
